// File: rtl/countdown_display_pkg.sv
// Shared constants for the MM:SS countdown display: segment codes,
// digit slot numbering and the seconds-to-BCD converter state encoding.
package countdown_display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] DIG_SEC_U = 2'd0;
  localparam logic [1:0] DIG_SEC_T = 2'd1;
  localparam logic [1:0] DIG_MIN_U = 2'd2;
  localparam logic [1:0] DIG_MIN_T = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  function automatic logic [5:0] clamp_sec(input logic [5:0] sec);
    return (sec > 6'd59) ? 6'd59 : sec;
  endfunction

endpackage

// File: rtl/countdown_display_sec_bcd_converter.sv
// Sequential subtract-10 seconds-to-BCD converter. A start captures the
// inputs; the display digits are only ever loaded whole in DONE.
module sec_bcd_converter
  import countdown_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  min_in,
  input  logic [5:0]  sec_in,
  output logic [3:0]  min_digit,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_units,
  output logic        valid,
  output logic        expired,
  output conv_state_e state
);

  conv_state_e state_next;
  logic [5:0]  rem;
  logic [3:0]  tens;
  logic [1:0]  min_hold;
  logic        capture;
  logic        sub_step;
  logic        load;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (rem < 6'd10) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture  = (state == IDLE) && start;
    sub_step = (state == CONV) && (rem >= 6'd10);
    load     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      tens      <= '0;
      min_hold  <= '0;
      min_digit <= '0;
      sec_tens  <= '0;
      sec_units <= '0;
      valid     <= 1'b0;
      expired   <= 1'b0;
    end else begin
      if (capture) begin
        rem      <= clamp_sec(sec_in);
        tens     <= '0;
        min_hold <= min_in;
      end
      if (sub_step) begin
        rem  <= rem - 6'd10;
        tens <= tens + 4'd1;
      end
      if (load) begin
        min_digit <= {2'b00, min_hold};
        sec_tens  <= tens;
        sec_units <= rem[3:0];
        valid     <= 1'b1;
        expired   <= (min_hold == 2'd0) && (tens == 4'd0) && (rem == 6'd0);
      end
    end
  end

endmodule

// File: rtl/countdown_display.sv
// Multiplexed 4-digit common-anode MM:SS display for the countdown timer,
// with colon blink while held and whole-display blink at 00:00.
module countdown_display
  import countdown_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [1:0] minutes,
  input  logic [5:0] seconds,
  input  logic       hold,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       dp_n,
  output logic       expired
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc;
  logic [1:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          scan_tick;
  logic          frame_tick;

  conv_state_e   conv_state;
  logic [3:0]    min_digit;
  logic [3:0]    sec_tens;
  logic [3:0]    sec_units;
  logic          valid;

  logic          blank_all;
  logic [3:0]    digit_val;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;
  logic          dp_next;

  assign scan_tick  = (presc == PW'(REFRESH_DIV - 1));
  assign frame_tick = scan_tick && (digit_idx == DIG_MIN_T);

  always_ff @(posedge CLK) begin
    if (rst) begin
      presc     <= '0;
      digit_idx <= DIG_SEC_U;
    end else if (scan_tick) begin
      presc     <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      presc     <= presc + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BW'(1);
      end
    end
  end

  sec_bcd_converter u_conv (
    .clk       (CLK),
    .rst       (rst),
    .start     (frame_tick && (conv_state == IDLE)),
    .min_in    (minutes),
    .sec_in    (seconds),
    .min_digit (min_digit),
    .sec_tens  (sec_tens),
    .sec_units (sec_units),
    .valid     (valid),
    .expired   (expired),
    .state     (conv_state)
  );

  // Slot DIG_MIN_T keeps its anode driven but shows nothing, so every slot
  // has the same duty cycle.
  always_comb begin
    blank_all = !valid || (expired && blink_phase);
    case (digit_idx)
      DIG_SEC_U: digit_val = sec_units;
      DIG_SEC_T: digit_val = sec_tens;
      DIG_MIN_U: digit_val = min_digit;
      default:   digit_val = 4'hF;
    endcase
    seg_next = blank_all ? SEG_BLANK : seg_encode(digit_val);
    an_next  = 4'hF;
    if (!blank_all) an_next[digit_idx] = 1'b0;
    dp_next  = !((digit_idx == DIG_MIN_U) && !blank_all && (!hold || !blink_phase));
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      seg_n <= SEG_BLANK;
      an_n  <= 4'hF;
      dp_n  <= 1'b1;
    end else begin
      seg_n <= seg_next;
      an_n  <= an_next;
      dp_n  <= dp_next;
    end
  end

endmodule

// File: tb/tb_countdown_display.sv
// Self-checking bench for countdown_display: a frame-level model predicts
// every digit slot from the inputs captured at each frame start.
module tb_countdown_display;

  localparam int D  = 16;
  localparam int BF = 3;
  localparam int FR = 4 * D;

  logic       clk;
  logic       rst;
  logic [1:0] minutes;
  logic [5:0] seconds;
  logic       hold;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       dp_n;
  logic       expired;

  logic [12:0] obs;
  logic [12:0] e;
  assign obs = {an_n, seg_n, dp_n, expired};

  int tests_run;
  int failed;
  int n;
  int fm[int];
  int fs[int];

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  countdown_display #(.REFRESH_DIV(D), .BLINK_FRAMES(BF)) dut (
    .CLK     (clk),
    .rst     (rst),
    .minutes (minutes),
    .seconds (seconds),
    .hold    (hold),
    .seg_n   (seg_n),
    .an_n    (an_n),
    .dp_n    (dp_n),
    .expired (expired)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an_n, seg_n, dp_n, expired} for the slot ending at edge k
  // (k a multiple of D) counted from reset release.
  function automatic logic [12:0] model_slot(input int k);
    int f, s, d, mm, ss;
    logic ph, vld, expd, blank, dp;
    logic [3:0] an;
    logic [6:0] sg;
    f   = (k - 1) / FR;
    s   = ((k / D) - 1) % 4;
    ph  = ((f / BF) % 2) == 1;
    vld = fs.exists(f);
    mm  = vld ? fm[f] : 0;
    ss  = vld ? fs[f] : 0;
    expd  = vld && (mm == 0) && (ss == 0);
    blank = !vld || (expd && ph);
    case (s)
      0:       d = ss % 10;
      1:       d = ss / 10;
      2:       d = mm;
      default: d = 10;
    endcase
    sg = (blank || d > 9) ? 7'h7F : seg_tab[d];
    an = 4'hF;
    if (!blank) an[s] = 1'b0;
    dp = !((s == 2) && !blank && (!hold || !ph));
    return {an, sg, dp, expd};
  endfunction

  // Driver: one clock; records the frame snapshot at each capture edge.
  task automatic step();
    int fr;
    if (((n + 1) % FR) == 0) begin
      fr = (n + 1) / FR;
      fm[fr] = int'(minutes);
      fs[fr] = (int'(seconds) > 59) ? 59 : int'(seconds);
    end
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; minutes = 2'd2; seconds = 6'd0; hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        failed++;
        $display("FAIL reset_values got %h want %h", obs, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
    end
    rst = 1'b0; n = 0; fm.delete(); fs.delete();
    for (int c = 0; c < 3 * FR; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL reset_then_200 n=%0d got %h want %h", n, obs, e); end
      end
    end
  endtask

  task automatic test_max_seconds();
    minutes = 2'd1; seconds = 6'd30; hold = 1'b0;
    for (int c = 0; c < FR; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL align_130 n=%0d got %h want %h", n, obs, e); end
        if (n % FR == 0) break;
      end
    end
    seconds = 6'd59;
    for (int c = 0; c < FR; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL frame_130 n=%0d got %h want %h", n, obs, e); end
      end
    end
    // 59 needs the longest conversion: old units until 8 edges after capture.
    repeat (7) step();
    tests_run++;
    if (seg_n !== seg_tab[0]) begin
      failed++; $display("FAIL conv_latency_old got %h want %h", seg_n, seg_tab[0]);
    end
    step();
    tests_run++;
    if (seg_n !== seg_tab[9]) begin
      failed++; $display("FAIL conv_latency_new got %h want %h", seg_n, seg_tab[9]);
    end
    for (int c = 0; c < 2 * FR; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL frame_159 n=%0d got %h want %h", n, obs, e); end
      end
    end
  endtask

  task automatic test_clamp_and_expire();
    minutes = 2'd1; seconds = 6'd63; hold = 1'b0;
    for (int c = 0; c < 2 * FR; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL clamp_63 n=%0d got %h want %h", n, obs, e); end
      end
    end
    minutes = 2'd0; seconds = 6'd0;
    for (int c = 0; c < (2 * BF + 2) * FR; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL expire_blink n=%0d got %h want %h", n, obs, e); end
      end
    end
  endtask

  task automatic test_hold_colon();
    minutes = 2'd1; seconds = 6'd30; hold = 1'b1;
    for (int c = 0; c < (2 * BF + 1) * FR; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL hold_colon n=%0d got %h want %h", n, obs, e); end
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_rst_mid_conv();
    bit done;
    minutes = 2'd2; seconds = 6'd45; hold = 1'b0;
    done = 0;
    for (int c = 0; c < 3 * FR && !done; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL pre_rst n=%0d got %h want %h", n, obs, e); end
      end
      if (n > FR && n % FR == 2) done = 1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failed++; $display("FAIL rst_mid_conv got %h want %h", obs, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    rst = 1'b0; n = 0; fm.delete(); fs.delete();
    for (int c = 0; c < 3 * FR; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL post_rst n=%0d got %h want %h", n, obs, e); end
      end
    end
  endtask

  task automatic test_change_mid_conv();
    bit changed;
    minutes = 2'd0; seconds = 6'd10; hold = 1'b0;
    changed = 0;
    for (int c = 0; c < 4 * FR; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL mid_conv_change n=%0d got %h want %h", n, obs, e); end
      end
      if (!changed && n > FR && n % FR == 2) begin
        seconds = 6'd9;
        changed = 1;
      end
    end
  endtask

  task automatic test_random();
    int rp;
    rp = $urandom_range(1, FR - 1);
    for (int c = 0; c < 10 * FR; c++) begin
      step();
      if (n % D == 0) begin
        tests_run++; e = model_slot(n);
        if (obs !== e) begin failed++; $display("FAIL random n=%0d got %h want %h", n, obs, e); end
      end
      if (n % FR == rp) begin
        minutes = 2'($urandom_range(0, 2));
        seconds = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 4) == 0) begin
          minutes = 2'd0; seconds = 6'd0;
        end
        hold = 1'($urandom_range(0, 1));
        rp = $urandom_range(1, FR - 1);
      end
    end
  endtask

  initial begin
    tests_run = 0; failed = 0; n = 0;
    rst = 1'b1; minutes = 2'd0; seconds = 6'd0; hold = 1'b0;
    test_reset();
    test_max_seconds();
    test_clamp_and_expire();
    test_hold_colon();
    test_rst_mid_conv();
    test_change_mid_conv();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
